// File: rtl/accel_pkg.sv
// Shared types and constants for the Accelerant mesh PE programming path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accel_pkg;

    localparam int PE_INSTR_W = 4;
    localparam int PE_DATA_W  = 32;

    // Programming-session sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } cfg_state_e;

    // PE functional-unit select opcodes.
    localparam logic [PE_INSTR_W-1:0] FADD    = 4'b0000;
    localparam logic [PE_INSTR_W-1:0] FMUL    = 4'b0001;
    localparam logic [PE_INSTR_W-1:0] FMA     = 4'b0011;
    localparam logic [PE_INSTR_W-1:0] SYS_FMA = 4'b1010;

endpackage

// File: rtl/pe_id_decoder.sv
// PE index to one-hot select, flagging indices beyond the populated mesh.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the index.
module pe_id_decoder #(
    parameter int NUM_PE = 16,
    parameter int ID_W   = $clog2(NUM_PE)
) (
    input  logic [ID_W:0]      id_i,
    output logic [NUM_PE-1:0]  onehot_o,
    output logic               oor_o
);

    localparam logic [ID_W:0] NUM_PE_ID = (ID_W+1)'(NUM_PE);

    // Out-of-range IDs produce an all-zero select so nothing downstream fires.
    always_comb begin
        onehot_o = '0;
        oor_o    = (id_i >= NUM_PE_ID);
        for (int i = 0; i < NUM_PE; i++) begin
            if (id_i == (ID_W+1)'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_config_loader.sv
// Programming-phase master: clears all PEs, then streams per-PE instruction/data loads.
// Latency: pe_load/pe_data appear one cycle after the accepting handshake.
// Backpressure: cfg_ready high only in LOAD; one record per cycle sustained there.
module pe_config_loader
    import accel_pkg::*;
#(
    parameter int NUM_PE     = 16,
    parameter int CLR_CYCLES = 2,
    parameter int ID_W       = $clog2(NUM_PE)
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [ID_W:0]                          cfg_pe_id,
    input  logic [PE_INSTR_W-1:0]                  cfg_instr,
    input  logic [PE_DATA_W-1:0]                   cfg_data,
    input  logic                                   cfg_last,
    output logic                                   pe_reset,
    output logic [NUM_PE-1:0]                      pe_load,
    output logic [PE_DATA_W-1:0]                   pe_data,
    output logic [NUM_PE-1:0][PE_INSTR_W-1:0]      pe_instruction,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   incomplete,
    output logic                                   id_error
);

    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CLR_CYCLES - 1);

    cfg_state_e                            state_q, state_d;
    logic [CNT_W-1:0]                      clr_cnt_q, clr_cnt_d;
    logic [NUM_PE-1:0]                     mask_q, mask_d;
    logic [NUM_PE-1:0]                     load_q, load_d;
    logic [PE_DATA_W-1:0]                  data_q, data_d;
    logic [NUM_PE-1:0][PE_INSTR_W-1:0]     instr_q, instr_d;
    logic                                  id_error_q, id_error_d;
    logic                                  incomplete_q, incomplete_d;

    logic                                  session_clr;
    logic                                  hs;
    logic [NUM_PE-1:0]                     id_onehot;
    logic                                  id_oor;

    pe_id_decoder #(
        .NUM_PE (NUM_PE),
        .ID_W   (ID_W)
    ) u_id_dec (
        .id_i     (cfg_pe_id),
        .onehot_o (id_onehot),
        .oor_o    (id_oor)
    );

    // A record counts only if accepted outside an abort cycle.
    assign hs = cfg_valid & cfg_ready & ~abort;

    // Session sequencer: next state plus the state-decoded handshake/status outputs.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        session_clr = 1'b0;
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        pe_reset    = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = CLEAR;
                    clr_cnt_d   = CNT_INIT;
                    session_clr = 1'b1;
                end
            end
            CLEAR: begin
                pe_reset = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (clr_cnt_q == '0) begin
                    state_d = LOAD;
                end else begin
                    clr_cnt_d = clr_cnt_q - 1'b1;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (cfg_valid && cfg_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = ~abort;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load datapath: strobe, broadcast data, held instructions and session flags.
    always_comb begin
        load_d       = '0;
        data_d       = data_q;
        instr_d      = instr_q;
        mask_d       = mask_q;
        id_error_d   = id_error_q;
        incomplete_d = incomplete_q;
        if (session_clr) begin
            mask_d       = '0;
            instr_d      = '0;
            id_error_d   = 1'b0;
            incomplete_d = 1'b0;
        end
        if (hs) begin
            if (id_oor) begin
                id_error_d = 1'b1;
            end else begin
                load_d = id_onehot;
                data_d = cfg_data;
                mask_d = mask_q | id_onehot;
                for (int i = 0; i < NUM_PE; i++) begin
                    if (id_onehot[i]) begin
                        instr_d[i] = cfg_instr;
                    end
                end
            end
        end
        if (done) begin
            incomplete_d = incomplete_q | ~(&mask_q);
        end
    end

    // State and datapath registers; reset returns everything to the idle, cleared state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            mask_q       <= '0;
            load_q       <= '0;
            data_q       <= '0;
            instr_q      <= '0;
            id_error_q   <= 1'b0;
            incomplete_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            mask_q       <= mask_d;
            load_q       <= load_d;
            data_q       <= data_d;
            instr_q      <= instr_d;
            id_error_q   <= id_error_d;
            incomplete_q <= incomplete_d;
        end
    end

    assign pe_load        = load_q;
    assign pe_data        = data_q;
    assign pe_instruction = instr_q;
    assign id_error       = id_error_q;
    // Visible in the done cycle itself, then sticky until the next session.
    assign incomplete     = incomplete_q | (done & ~(&mask_q));

endmodule

// File: tb/tb_pe_config_loader.sv
// Scoreboard bench for pe_config_loader with a record-level reference model.
// Latency: expects each in-range accepted record to load one cycle later.
// Backpressure: driver holds a record until cfg_ready is seen.
module tb_pe_config_loader;
    import accel_pkg::*;

    localparam int NPE = 16;
    localparam int CLR = 2;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic [4:0]            cfg_pe_id = '0;
    logic [3:0]            cfg_instr = '0;
    logic [31:0]           cfg_data = '0;
    logic                  cfg_last = 1'b0;
    logic                  pe_reset;
    logic [NPE-1:0]        pe_load;
    logic [31:0]           pe_data;
    logic [NPE-1:0][3:0]   pe_instruction;
    logic                  busy;
    logic                  done;
    logic                  incomplete;
    logic                  id_error;

    pe_config_loader #(.NUM_PE(NPE), .CLR_CYCLES(CLR)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_pe_id      (cfg_pe_id),
        .cfg_instr      (cfg_instr),
        .cfg_data       (cfg_data),
        .cfg_last       (cfg_last),
        .pe_reset       (pe_reset),
        .pe_load        (pe_load),
        .pe_data        (pe_data),
        .pe_instruction (pe_instruction),
        .busy           (busy),
        .done           (done),
        .incomplete     (incomplete),
        .id_error       (id_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          exp_done_cnt = 0;
    int          cyc = 0;
    logic [3:0]  m_instr[NPE];
    bit [NPE-1:0] m_mask = '0;
    bit          m_iderr = 1'b0;
    bit          exp_last_inrange = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_vec();
        logic [63:0] v;
        for (int i = 0; i < NPE; i++) v[i*4 +: 4] = m_instr[i];
        return v;
    endfunction

    task automatic model_clear();
        m_mask  = '0;
        m_iderr = 1'b0;
        for (int i = 0; i < NPE; i++) m_instr[i] = 4'h0;
    endtask

    // Reference model: an accepted record either targets a real PE or flags an error.
    task automatic model_accept(input int id, input logic [3:0] ins, input logic [31:0] d, input bit last);
        exp_t e;
        if (id < NPE) begin
            e.id = id;
            e.data = d;
            exp_q.push_back(e);
            m_instr[id] = ins;
            m_mask[id] = 1'b1;
        end else begin
            m_iderr = 1'b1;
        end
        if (last) begin
            exp_done_cnt++;
            exp_last_inrange = (id < NPE);
        end
    endtask

    // Monitor: every load strobe must match the oldest outstanding expected load.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pe_load != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", 64'(pe_load), 64'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("load_sel", 64'(pe_load), 64'(16'h1 << e.id));
                    chk("load_data", 64'(pe_data), 64'(e.data));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_incomplete", 64'(incomplete), 64'(m_mask != '1));
                chk("done_id_error", 64'(id_error), 64'(m_iderr));
                chk("done_last_load", 64'(pe_load != '0), 64'(exp_last_inrange));
            end
        end
    end

    task automatic begin_session();
        int n;
        bit got;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
        n = 0;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cfg_ready) begin
                got = 1'b1;
                break;
            end
            if (pe_reset) n++;
        end
        chk("clr_cycles", 64'(n), 64'(CLR));
        chk("ready_after_clear", 64'(got), 64'h1);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [4:0] id, input logic [3:0] ins, input logic [31:0] d,
                        input bit last, input bit gap);
        bit ok;
        ok = 1'b0;
        cfg_valid = 1'b1;
        cfg_pe_id = id;
        cfg_instr = ins;
        cfg_data  = d;
        cfg_last  = last;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cfg_ready) begin
                ok = 1'b1;
                model_accept(int'(id), ins, d, last);
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: id %0d never accepted (ready 0, required 1)", id);
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic post_check(input string tag, input bit exp_inc);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_id_error"}, 64'(id_error), 64'(m_iderr));
        chk({tag, "_incomplete"}, 64'(incomplete), 64'(exp_inc));
        chk({tag, "_instr"}, 64'(pe_instruction), model_vec());
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done_cnt));
    endtask

    initial begin
        int c0;
        model_clear();
        // Reset state.
        #12;
        chk("rst_outputs", {58'h0, pe_reset, cfg_ready, busy, done, incomplete, id_error}, 64'h0);
        chk("rst_load", 64'(pe_load), 64'h0);
        chk("rst_data", 64'(pe_data), 64'h0);
        chk("rst_instr", 64'(pe_instruction), 64'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_outputs", {59'h0, pe_reset, cfg_ready, busy, done, id_error}, 64'h0);

        // Full sweep, back-to-back.
        begin_session();
        c0 = cyc;
        for (int i = 0; i < NPE; i++)
            send(5'(i), FMUL, 32'h3F80_0000 + 32'(i), i == NPE - 1, 1'b0);
        chk("b2b_cycles", 64'(cyc - c0), 64'(NPE));
        post_check("full", 1'b0);

        // Duplicate ID: later record wins, incomplete at done.
        begin_session();
        send(5'd3, SYS_FMA, 32'h4000_0000, 1'b0, 1'b0);
        send(5'd3, FADD, 32'h0, 1'b1, 1'b0);
        post_check("dup", 1'b1);
        chk("dup_pe3", 64'(pe_instruction[3]), 64'h0);

        // Out-of-range ID mid-stream among random records.
        begin_session();
        for (int i = 0; i < 6; i++) begin
            if (i == 2) send(5'd20, FMA, $urandom, 1'b0, 1'b0);
            else send(5'($urandom_range(0, NPE - 1)), 4'($urandom), $urandom, i == 5, 1'b0);
        end
        post_check("oor", 1'b1);
        chk("oor_sticky", 64'(id_error), 64'h1);

        // Abort coincident with a handshake on PE 5.
        begin_session();
        send(5'd1, FMA, $urandom, 1'b0, 1'b0);
        send(5'd9, FMUL, $urandom, 1'b0, 1'b0);
        cfg_valid = 1'b1;
        cfg_pe_id = 5'd5;
        cfg_instr = SYS_FMA;
        cfg_data  = 32'hDEAD_BEEF;
        abort     = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        chk("abort_idle", {61'h0, busy, cfg_ready, pe_reset}, 64'h0);
        @(posedge clk); #1;
        post_check("abort", 1'b0);
        chk("abort_pe5", 64'(pe_instruction[5]), 64'h0);

        // Toggled valid with a stray start during LOAD.
        begin_session();
        for (int i = 0; i < 8; i++) begin
            send(5'($urandom_range(0, NPE - 1)), 4'($urandom), $urandom, i == 7, 1'b1);
            if (i == 3) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                chk("start_ignored", {62'h0, busy, cfg_ready}, 64'h3);
                @(posedge clk); #1;
            end
        end
        post_check("toggle", m_mask != '1);

        // Reset asserted while a load is being presented.
        begin_session();
        cfg_valid = 1'b1;
        cfg_pe_id = 5'd7;
        cfg_instr = FMA;
        cfg_data  = 32'h1234_5678;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        chk("pre_rst_load", 64'(pe_load), 64'(16'h1 << 7));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_load", 64'(pe_load), 64'h0);
        chk("mid_rst_state", {61'h0, busy, cfg_ready, pe_reset}, 64'h0);
        chk("mid_rst_instr", 64'(pe_instruction), 64'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        chk("total_done", 64'(done_cnt), 64'(exp_done_cnt));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
